// File: rtl/traffic_light_controller.sv
// Timed Moore controller for a main/side street intersection with a pedestrian walk phase.
// Every phase length is a count of tick_en pulses; all lamp outputs are registered with the state.
module traffic_light_controller #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       tick_en,
  input  logic       sensor_in,
  input  logic       walkRegister_status,
  output logic       walkRegister_reset,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G1  = 3'd0,
    MAIN_G2  = 3'd1,
    MAIN_Y   = 3'd2,
    WALK     = 3'd3,
    SIDE_G   = 3'd4,
    SIDE_EXT = 3'd5,
    SIDE_Y   = 3'd6
  } phaseT;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [7:0] D_BASE = 8'(T_BASE);
  localparam logic [7:0] D_EXT  = 8'(T_EXT);
  localparam logic [7:0] D_YEL  = 8'(T_YEL);

  phaseT      state;
  phaseT      nextState;
  logic [7:0] count;
  logic [7:0] duration;
  logic       g2Short;
  logic       expire;

  function automatic logic [2:0] mainLamp(input phaseT s);
    case (s)
      MAIN_G1, MAIN_G2: mainLamp = LAMP_G;
      MAIN_Y:           mainLamp = LAMP_Y;
      default:          mainLamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] sideLamp(input phaseT s);
    case (s)
      SIDE_G, SIDE_EXT: sideLamp = LAMP_G;
      SIDE_Y:           sideLamp = LAMP_Y;
      default:          sideLamp = LAMP_R;
    endcase
  endfunction

  // MAIN_G2 length was fixed by the sensor level seen when MAIN_G1 expired
  always_comb begin
    duration = D_BASE;
    case (state)
      MAIN_G2:  duration = g2Short ? D_EXT : D_BASE;
      MAIN_Y:   duration = D_YEL;
      WALK:     duration = D_EXT;
      SIDE_EXT: duration = D_EXT;
      SIDE_Y:   duration = D_YEL;
      default:  duration = D_BASE;
    endcase
  end

  always_comb begin
    nextState = MAIN_G1;
    case (state)
      MAIN_G1:  nextState = MAIN_G2;
      MAIN_G2:  nextState = MAIN_Y;
      MAIN_Y:   nextState = walkRegister_status ? WALK : SIDE_G;
      WALK:     nextState = SIDE_G;
      SIDE_G:   nextState = sensor_in ? SIDE_EXT : SIDE_Y;
      SIDE_EXT: nextState = SIDE_Y;
      SIDE_Y:   nextState = MAIN_G1;
      default:  nextState = MAIN_G1;
    endcase
  end

  assign expire = tick_en && (count == duration - 8'd1);
  assign phase  = state;

  // A tick on the expiring edge belongs to the old state; the new one starts at zero
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state              <= MAIN_G1;
      count              <= 8'd0;
      g2Short            <= 1'b0;
      main_lights        <= LAMP_G;
      side_lights        <= LAMP_R;
      walk_lamp          <= 1'b0;
      walkRegister_reset <= 1'b1;
    end else begin
      walkRegister_reset <= 1'b0;
      if (expire) begin
        state       <= nextState;
        count       <= 8'd0;
        main_lights <= mainLamp(nextState);
        side_lights <= sideLamp(nextState);
        walk_lamp   <= (nextState == WALK);
        if (nextState == WALK) walkRegister_reset <= 1'b1;
        if (state == MAIN_G1) g2Short <= sensor_in;
      end else if (tick_en) begin
        count <= count + 8'd1;
      end
    end
  end

endmodule
